// File: rtl/ym_clkgen_bank.sv
// ym_clkgen_bank
// Clock-enable generator running entirely in the MCLK domain. It provides NCH
// programmable divided clock levels and a selectable dot clock. The dot clock
// can come from one of the channels or from a synchronised external clock.
// From the dot clock it derives edge pulses (c2 rising, c1 falling) and
// alternating half-rate pulses (hc1/hc2). Nothing here is used as a clock.
//
// Ports
//   MCLK       master clock; all registers update on its rising edge
//   rst        synchronous active-high reset
//   ch_en      per-channel run enable
//   period     channel i period in MCLK cycles, field [i*DIVW +: DIVW]
//   high       channel i high time in MCLK cycles, same field layout
//   ext_clk    asynchronous external dot clock
//   dot_ext    dot source request: 1 = ext_clk, 0 = channel dot_ch
//   dot_ch     channel index requested as the dot source
//   hres       half-clock phase resync, sampled on c1
//   clk_out    registered divided clock levels
//   rise/fall  one-cycle pulses on clk_out edges
//   c2/c1      dot clock rising/falling edge pulses
//   hc1/hc2    alternating half-rate pulses
//   dsel_busy  requested dot source differs from the active one
module ym_clkgen_bank #(
    parameter int NCH  = 4,
    parameter int DIVW = 5,
    parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 MCLK,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*DIVW-1:0]  period,
    input  logic [NCH*DIVW-1:0]  high,
    input  logic                 ext_clk,
    input  logic                 dot_ext,
    input  logic [CW-1:0]        dot_ch,
    input  logic                 hres,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       rise,
    output logic [NCH-1:0]       fall,
    output logic                 c2,
    output logic                 c1,
    output logic                 hc1,
    output logic                 hc2,
    output logic                 dsel_busy
);

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIVW-1:0] cnt_reg;
            logic [DIVW-1:0] ps_reg;
            logic [DIVW-1:0] hs_reg;
            logic [DIVW-1:0] cnt_next;
            logic [DIVW-1:0] p_in;
            logic [DIVW-1:0] h_in;
            logic            clk_reg;
            logic            clk_d_reg;
            logic            stall;
            logic            wrap;

            assign p_in     = period[gi*DIVW +: DIVW];
            assign h_in     = high[gi*DIVW +: DIVW];
            // Periods below 2 cannot produce a toggling waveform; park them.
            assign stall    = !ch_en[gi] || (ps_reg < DIVW'(2));
            assign wrap     = (cnt_reg == ps_reg - DIVW'(1));
            assign cnt_next = wrap ? '0 : cnt_reg + DIVW'(1);

            always_ff @(posedge MCLK) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    clk_reg   <= 1'b0;
                    clk_d_reg <= 1'b0;
                    ps_reg    <= p_in;
                    hs_reg    <= h_in;
                end else begin
                    clk_d_reg <= clk_reg;
                    if (stall) begin
                        cnt_reg <= '0;
                        clk_reg <= 1'b0;
                        ps_reg  <= p_in;
                        hs_reg  <= h_in;
                    end else begin
                        cnt_reg <= cnt_next;
                        // Shadow registers only take new settings at the
                        // wrap, so a period in flight always completes.
                        if (wrap) begin
                            ps_reg  <= p_in;
                            hs_reg  <= h_in;
                            clk_reg <= (cnt_next < h_in);
                        end else begin
                            clk_reg <= (cnt_next < hs_reg);
                        end
                    end
                end
            end

            assign clk_out[gi] = clk_reg;
            assign rise[gi]    = clk_reg & ~clk_d_reg;
            assign fall[gi]    = ~clk_reg & clk_d_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Dot clock source selection and edge / half-clock generation
    // ------------------------------------------------------------------
    logic          ext_s1_reg;
    logic          ext_s_reg;
    logic          cur_ext_reg;
    logic [CW-1:0] cur_ch_reg;
    logic          dclk_l_reg;
    logic          ph_reg;
    logic          src_ch;
    logic          src;
    logic          req_diff;

    // Out-of-range channel indices read as a constant-low source.
    always_comb begin
        src_ch = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch_reg == CW'(i)) begin
                src_ch = clk_out[i];
            end
        end
    end

    assign src = cur_ext_reg ? ext_s_reg : src_ch;

    // The channel index is irrelevant while the external source is requested.
    // Comparing against the live request makes a pending switch retarget to
    // whatever is asked for last.
    assign req_diff = (dot_ext != cur_ext_reg) ||
                      (!dot_ext && (dot_ch != cur_ch_reg));
    assign dsel_busy = req_diff;

    always_ff @(posedge MCLK) begin
        if (rst) begin
            ext_s1_reg  <= 1'b0;
            ext_s_reg   <= 1'b0;
            cur_ext_reg <= dot_ext;
            cur_ch_reg  <= dot_ch;
            dclk_l_reg  <= 1'b0;
            ph_reg      <= 1'b0;
        end else begin
            ext_s1_reg <= ext_clk;
            ext_s_reg  <= ext_s1_reg;
            dclk_l_reg <= src;
            // Switch only while the old source has rested low for a full
            // cycle, so no truncated high phase reaches c1/c2. A source that
            // never stays low for two consecutive cycles holds off the switch.
            if (req_diff && !src && !dclk_l_reg) begin
                cur_ext_reg <= dot_ext;
                cur_ch_reg  <= dot_ch;
            end
            if (c1) begin
                ph_reg <= hres ? 1'b0 : ~ph_reg;
            end
        end
    end

    assign c2  = src & ~dclk_l_reg;
    assign c1  = ~src & dclk_l_reg;
    assign hc1 = c2 & ~ph_reg;
    assign hc2 = c2 & ph_reg;

endmodule

// File: tb/tb_ym_clkgen_bank.sv
module tb_ym_clkgen_bank;

    localparam int NCH  = 4;
    localparam int DIVW = 5;
    localparam int CW   = 2;

    logic                MCLK = 1'b0;
    logic                rst;
    logic [NCH-1:0]      ch_en;
    logic [NCH*DIVW-1:0] period;
    logic [NCH*DIVW-1:0] high;
    logic                ext_clk;
    logic                dot_ext;
    logic [CW-1:0]       dot_ch;
    logic                hres;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      rise;
    logic [NCH-1:0]      fall;
    logic                c2;
    logic                c1;
    logic                hc1;
    logic                hc2;
    logic                dsel_busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ym_clkgen_bank #(.NCH(NCH), .DIVW(DIVW), .CW(CW)) dut (
        .MCLK      (MCLK),
        .rst       (rst),
        .ch_en     (ch_en),
        .period    (period),
        .high      (high),
        .ext_clk   (ext_clk),
        .dot_ext   (dot_ext),
        .dot_ch    (dot_ch),
        .hres      (hres),
        .clk_out   (clk_out),
        .rise      (rise),
        .fall      (fall),
        .c2        (c2),
        .c1        (c1),
        .hc1       (hc1),
        .hc2       (hc2),
        .dsel_busy (dsel_busy)
    );

    always #5 MCLK = ~MCLK;

    // Advance one MCLK edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic set_ch(input int i, input int p, input int h);
        period[i*DIVW +: DIVW] = DIVW'(p);
        high[i*DIVW +: DIVW]   = DIVW'(h);
    endtask

    task automatic defaults();
        ch_en   = '0;
        period  = '0;
        high    = '0;
        ext_clk = 1'b0;
        dot_ext = 1'b0;
        dot_ch  = '0;
        hres    = 1'b0;
    endtask

    // Leaves rst low right after an edge; the next tick is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        defaults();
        set_ch(0, 3, 1);
        set_ch(1, 2, 1);
        ch_en = '1;
        rst = 1'b1;
        tick(); tick(); tick();
        chk_cnt++; if (clk_out !== 4'b0000) $display("FAIL reset clk_out got %b exp 0000", clk_out); else pass_cnt++;
        chk_cnt++; if (rise !== 4'b0000) $display("FAIL reset rise got %b exp 0000", rise); else pass_cnt++;
        chk_cnt++; if (fall !== 4'b0000) $display("FAIL reset fall got %b exp 0000", fall); else pass_cnt++;
        chk_cnt++; if ({c2, c1} !== 2'b00) $display("FAIL reset c2c1 got %b exp 00", {c2, c1}); else pass_cnt++;
        chk_cnt++; if ({hc1, hc2} !== 2'b00) $display("FAIL reset hc got %b exp 00", {hc1, hc2}); else pass_cnt++;
        chk_cnt++; if (dsel_busy !== 1'b0) $display("FAIL reset dsel_busy got %b exp 0", dsel_busy); else pass_cnt++;
        $display("test_reset done");
    endtask

    // P=3/H=1: high on edges 3,6,9; fall on 4,7.
    task automatic test_basic();
        logic exp_clk, exp_f;
        defaults();
        set_ch(0, 3, 1);
        ch_en = 4'b0001;
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_clk = (e % 3 == 0);
            exp_f   = (e % 3 == 1) && (e > 1);
            chk_cnt++; if (clk_out[0] !== exp_clk) $display("FAIL basic clk e=%0d got %b exp %b", e, clk_out[0], exp_clk); else pass_cnt++;
            chk_cnt++; if (rise[0] !== exp_clk) $display("FAIL basic rise e=%0d got %b exp %b", e, rise[0], exp_clk); else pass_cnt++;
            chk_cnt++; if (fall[0] !== exp_f) $display("FAIL basic fall e=%0d got %b exp %b", e, fall[0], exp_f); else pass_cnt++;
        end
        $display("test_basic done");
    endtask

    // P=4/H=2 changed to P=6/H=3 after edge 5; new setting takes effect at the
    // wrap on edge 8.
    task automatic test_period_change();
        logic [1:14] pat;
        pat = 14'b10011001110001;
        defaults();
        set_ch(1, 4, 2);
        ch_en = 4'b0010;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            if (e == 6) set_ch(1, 6, 3);
            tick();
            chk_cnt++; if (clk_out[1] !== pat[e]) $display("FAIL pchg clk e=%0d got %b exp %b", e, clk_out[1], pat[e]); else pass_cnt++;
        end
        $display("test_period_change done");
    endtask

    // P=1 stays low; P=5/H=7 stays high; dropping ch_en gives one fall.
    task automatic test_edge_cases();
        defaults();
        set_ch(2, 1, 1);
        set_ch(3, 5, 7);
        ch_en = 4'b1100;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk_cnt++; if (clk_out[2] !== 1'b0) $display("FAIL p1 clk e=%0d got %b exp 0", e, clk_out[2]); else pass_cnt++;
            chk_cnt++; if ((rise[2] | fall[2]) !== 1'b0) $display("FAIL p1 pulse e=%0d got %b exp 0", e, rise[2] | fall[2]); else pass_cnt++;
            chk_cnt++; if (fall[3] !== 1'b0) $display("FAIL hgep fall e=%0d got %b exp 0", e, fall[3]); else pass_cnt++;
            if (e >= 5) begin
                chk_cnt++; if (clk_out[3] !== 1'b1) $display("FAIL hgep clk e=%0d got %b exp 1", e, clk_out[3]); else pass_cnt++;
            end
        end
        ch_en[3] = 1'b0;
        tick();
        chk_cnt++; if (clk_out[3] !== 1'b0) $display("FAIL chen_drop clk got %b exp 0", clk_out[3]); else pass_cnt++;
        chk_cnt++; if (fall[3] !== 1'b1) $display("FAIL chen_drop fall got %b exp 1", fall[3]); else pass_cnt++;
        $display("test_edge_cases done");
    endtask

    // Request ch2 while ch0 (P=2/H=1) is high; ch0 never rests low two cycles,
    // so the switch waits until ch0 is stopped after edge 6.
    task automatic test_dot_switch();
        logic exp_c2, exp_c1, exp_busy;
        int   last;
        defaults();
        set_ch(0, 2, 1);
        set_ch(2, 8, 4);
        ch_en = 4'b0101;
        do_reset();
        last = 0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 3) dot_ch = 2'd2;
            if (e == 7) ch_en[0] = 1'b0;
            tick();
            exp_c2   = (e == 2) || (e == 4) || (e == 6) || (e == 9);
            exp_c1   = (e == 3) || (e == 5) || (e == 7) || (e == 12);
            exp_busy = (e >= 3) && (e <= 8);
            chk_cnt++; if (c2 !== exp_c2) $display("FAIL dsw c2 e=%0d got %b exp %b", e, c2, exp_c2); else pass_cnt++;
            chk_cnt++; if (c1 !== exp_c1) $display("FAIL dsw c1 e=%0d got %b exp %b", e, c1, exp_c1); else pass_cnt++;
            chk_cnt++; if (dsel_busy !== exp_busy) $display("FAIL dsw busy e=%0d got %b exp %b", e, dsel_busy, exp_busy); else pass_cnt++;
            if (c2 === 1'b1 || c1 === 1'b1) begin
                chk_cnt++;
                if ((c2 & c1) !== 1'b0 || (c2 === 1'b1 && last == 1) || (c1 === 1'b1 && last == 2))
                    $display("FAIL dsw order e=%0d got c2=%b c1=%b last=%0d exp alternating", e, c2, c1, last);
                else
                    pass_cnt++;
                last = (c2 === 1'b1) ? 1 : 2;
            end
        end
        $display("test_dot_switch done");
    endtask

    // Dot source P=2/H=1: c2 on even edges, hc1/hc2 alternate; hres held over
    // the c1 after edge 11 forces hc1 again at edge 12.
    task automatic test_halfclock();
        logic exp_c2, exp_c1, exp_h1, exp_h2;
        defaults();
        set_ch(0, 2, 1);
        ch_en = 4'b0001;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            if (e == 11) hres = 1'b1;
            if (e == 13) hres = 1'b0;
            tick();
            exp_c2 = (e % 2 == 0);
            exp_c1 = (e % 2 == 1) && (e >= 3);
            exp_h1 = (e == 2) || (e == 6) || (e == 10) || (e == 12);
            exp_h2 = (e == 4) || (e == 8) || (e == 14);
            chk_cnt++; if (c2 !== exp_c2) $display("FAIL hclk c2 e=%0d got %b exp %b", e, c2, exp_c2); else pass_cnt++;
            chk_cnt++; if (c1 !== exp_c1) $display("FAIL hclk c1 e=%0d got %b exp %b", e, c1, exp_c1); else pass_cnt++;
            chk_cnt++; if (hc1 !== exp_h1) $display("FAIL hclk hc1 e=%0d got %b exp %b", e, hc1, exp_h1); else pass_cnt++;
            chk_cnt++; if (hc2 !== exp_h2) $display("FAIL hclk hc2 e=%0d got %b exp %b", e, hc2, exp_h2); else pass_cnt++;
        end
        $display("test_halfclock done");
    endtask

    // ext_clk period 10 MCLK; a rise driven before edge n shows as c2 after
    // edge n+1. Then reset mid-run where a c2 would otherwise appear.
    task automatic test_ext();
        logic exp_c2, exp_c1;
        defaults();
        set_ch(0, 3, 1);
        ch_en   = 4'b0001;
        dot_ext = 1'b1;
        do_reset();
        for (int n = 0; n <= 30; n++) begin
            ext_clk = (n % 10 < 5);
            tick();
            exp_c2 = (n % 10 == 1);
            exp_c1 = (n % 10 == 6);
            chk_cnt++; if (c2 !== exp_c2) $display("FAIL ext c2 n=%0d got %b exp %b", n, c2, exp_c2); else pass_cnt++;
            chk_cnt++; if (c1 !== exp_c1) $display("FAIL ext c1 n=%0d got %b exp %b", n, c1, exp_c1); else pass_cnt++;
        end
        ext_clk = 1'b1;
        rst = 1'b1;
        tick();
        chk_cnt++; if ({c2, c1, hc1, hc2} !== 4'b0000) $display("FAIL midrst dot got %b exp 0000", {c2, c1, hc1, hc2}); else pass_cnt++;
        chk_cnt++; if ({clk_out, rise, fall} !== 12'h000) $display("FAIL midrst ch got %h exp 000", {clk_out, rise, fall}); else pass_cnt++;
        chk_cnt++; if (dsel_busy !== 1'b0) $display("FAIL midrst busy got %b exp 0", dsel_busy); else pass_cnt++;
        rst = 1'b0;
        $display("test_ext done");
    endtask

    initial begin
        rst = 1'b1;
        defaults();
        test_reset();
        test_basic();
        test_period_change();
        test_edge_cases();
        test_dot_switch();
        test_halfclock();
        test_ext();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
